serial_memory: RTL
==================

Name: serial_memory

Overview:
- Parametrised successor to the plain RTL memory array: a single-port word memory behind a narrow serial command interface, for pin-limited on-chip memory test.
- Host shifts in a header (write flag + address) and, for writes, data, over SERIAL_BITS-wide beats with valid/ready handshaking.
- Read data is shifted back out over a separate valid/ready port.
- Sits between the top-level pin mux and the storage array.

Parameters:
- ADDR_BITS, 5, word address width; depth = 2**ADDR_BITS.
- DATA_BITS, 8, word width; must be a multiple of SERIAL_BITS.
- SERIAL_BITS, 2, beat width on serial_in and serial_out.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- serial_in  in  SERIAL_BITS  input beat.
- in_valid  in  1  serial_in holds a beat.
- in_ready  out  1  block accepts a beat this cycle.
- serial_out  out  SERIAL_BITS  read-data beat.
- out_valid  out  1  serial_out holds a beat.
- out_ready  in  1  host accepts the serial_out beat.
- busy  out  1  high in every state except HDR with hdr_cnt==0.
- parity_err  out  1  read parity mismatch flag; see Optional Feature.

Behaviour:
- Constants: HDR_BEATS = ceil((1+ADDR_BITS)/SERIAL_BITS); DATA_BEATS = DATA_BITS/SERIAL_BITS.
- Header word: bit 0 = we; bits [ADDR_BITS:1] = addr; upper pad bits ignored.
- All shifting is LSB-first: the first beat carries bits [SERIAL_BITS-1:0].
- A beat transfers only on a cycle where in_valid && in_ready, or out_valid && out_ready.
- States:
  - HDR: in_ready=1. Shift each accepted beat into the header register. On the beat where hdr_cnt==HDR_BEATS-1, go to WDATA if we=1, else READ. hdr_cnt then returns to 0.
  - WDATA: in_ready=1. Shift accepted beats into the data register. On the last beat, go to WRITE.
  - WRITE: one cycle, in_ready=0. The array is written with {addr, data} on this edge. Next state is HDR.
  - READ: one cycle, in_ready=0. The array is read combinationally and rdata is loaded into the output shift register. Next state is RDATA.
  - RDATA: out_valid=1 and serial_out = shift_reg[SERIAL_BITS-1:0]. On each transfer, shift right by SERIAL_BITS. After DATA_BEATS transfers, go to HDR.
- Latency:
  - Write: the word is visible to a read header that completes 2 cycles after the last data beat.
  - Read: the first output beat is valid 2 cycles after the last header beat.
- out_valid and serial_out are registered. serial_out is 0 whenever out_valid=0.
- In HDR and WDATA, in_valid=0 stalls the state and counters indefinitely. In RDATA, out_ready=0 holds serial_out stable.
- in_ready is 0 in WRITE, READ and RDATA. Input beats offered in those states are not consumed.
- Reset values: state=HDR, all counters 0, shift registers 0, out_valid=0, serial_out=0, parity_err=0, busy=0. in_ready is 1 after reset.
- Reset mid-transaction: the transaction is aborted and no write occurs. Array contents are not cleared by reset.
- The array itself has no reset; reading a never-written word returns undefined data.
- Address wrap is not applicable: all 2**ADDR_BITS addresses are valid.

Optional Feature:
- Macro: SERIAL_MEMORY_PARITY_EN.
- Defined:
  - The array stores DATA_BITS+1 bits per word; the extra bit is even parity (XOR of data), computed in WRITE.
  - In READ, parity_err is registered as the stored parity XOR the recomputed parity, and holds until the next READ or reset.
- Undefined:
  - The array is DATA_BITS wide and parity_err is tied 0.
  - The port is present in both builds.

Decomposition:
- Shared package holds:
  - state enum (HDR, WDATA, WRITE, READ, RDATA);
  - HDR_BEATS and DATA_BEATS computation as functions of the parameters;
  - beat-counter width = clog2 of max(HDR_BEATS, DATA_BEATS), minimum 1.
- Sub-module mem_array holds the storage: parametrised width and depth, combinational read, synchronous write enable, no reset. The array width gains the parity bit under the macro.
- Control FSM, shift registers and counters live in serial_memory.

Test Plan (defaults: ADDR_BITS=5, DATA_BITS=8, SERIAL_BITS=2; HDR_BEATS=3, DATA_BEATS=4):
- Write 0xA5 to addr 0x13: beats 3,1,2 then 1,1,2,2 -> busy returns to 0 two cycles later. Read addr 0x13 (beats 2,1,2) -> serial_out beats 1,1,2,2, with out_valid first high 2 cycles after the last header beat.
- Backpressure: in the 0x13 read, hold out_ready=0 for 5 cycles before the 2nd beat -> serial_out holds 1 and out_valid holds 1; the full sequence is still 1,1,2,2.
- Input gaps: deassert in_valid between every beat of a write of 0x3C to addr 0 -> a readback returns 0x3C. Beats offered while in_ready=0 are not consumed.
- Reset mid-write: write 0x11 to addr 5, then write 0xFF to addr 5 but assert reset after 2 of the 4 data beats -> a readback of addr 5 returns 0x11; post-reset outputs are all 0 and in_ready=1.
- Full sweep: write addr^0x5A to all 32 addresses, then read all 32 -> every word matches, confirming no aliasing at 0x00 and 0x1F.
- With SERIAL_MEMORY_PARITY_EN: write 0x80 to addr 7, force the stored parity bit inverted via hierarchical access, read addr 7 -> parity_err=1. A subsequent clean read of addr 0 -> parity_err=0.

Source files
------------

// File: rtl/serial_memory_pkg.sv
// Shared types and sizing helpers for the serial_memory block.
package serial_memory_pkg;

  typedef enum logic [2:0] {
    HDR,
    WDATA,
    WRITE,
    READ,
    RDATA
  } state_t;

  // Header carries the write flag plus the address, rounded up to whole beats.
  function automatic int hdr_beats(input int addr_bits, input int serial_bits);
    return (addr_bits + serial_bits) / serial_bits;
  endfunction

  function automatic int data_beats(input int data_bits, input int serial_bits);
    return data_bits / serial_bits;
  endfunction

  function automatic int cnt_width(input int addr_bits, input int data_bits,
                                   input int serial_bits);
    int m;
    m = hdr_beats(addr_bits, serial_bits);
    if (data_beats(data_bits, serial_bits) > m) m = data_beats(data_bits, serial_bits);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_memory_mem_array.sv
// Single-port word storage: combinational read, synchronous write, no reset.
module serial_memory_mem_array #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: storage is deliberately left out of reset so it maps onto plain array cells.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/serial_memory.sv
// Serial command front end for a word memory: header/data beats in, read beats out.
// Optional read parity checking is enabled with `define SERIAL_MEMORY_PARITY_EN.
module serial_memory
  import serial_memory_pkg::*;
#(
  parameter int ADDR_BITS   = 5,
  parameter int DATA_BITS   = 8,
  parameter int SERIAL_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SERIAL_BITS-1:0] serial_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [SERIAL_BITS-1:0] serial_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   parity_err
);

  localparam int HDR_BEATS  = hdr_beats(ADDR_BITS, SERIAL_BITS);
  localparam int DATA_BEATS = data_beats(DATA_BITS, SERIAL_BITS);
  localparam int CNT_W      = cnt_width(ADDR_BITS, DATA_BITS, SERIAL_BITS);
  localparam int HDR_W      = HDR_BEATS * SERIAL_BITS;
`ifdef SERIAL_MEMORY_PARITY_EN
  localparam int MEM_W      = DATA_BITS + 1;
`else
  localparam int MEM_W      = DATA_BITS;
`endif

  state_t               state, next_state;
  logic [CNT_W-1:0]     hdr_cnt, beat_cnt;
  logic [HDR_W-1:0]     hdr_reg, hdr_next;
  logic [DATA_BITS-1:0] data_reg, data_next, data_shifted;
  logic [ADDR_BITS-1:0] addr;
  logic [MEM_W-1:0]     mem_wdata, mem_rdata;
  logic                 mem_we, in_fire, out_fire, hdr_last, data_last;
  logic                 unused_hdr;

  // Beats enter at the top so the first (LSB) beat ends up at bit 0.
  assign hdr_next     = (hdr_reg >> SERIAL_BITS) | (HDR_W'(serial_in) << (HDR_W - SERIAL_BITS));
  assign data_next    = (data_reg >> SERIAL_BITS) |
                        (DATA_BITS'(serial_in) << (DATA_BITS - SERIAL_BITS));
  assign data_shifted = data_reg >> SERIAL_BITS;
  assign addr         = hdr_reg[ADDR_BITS:1];
  assign unused_hdr   = ^hdr_reg;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign hdr_last  = (hdr_cnt == CNT_W'(HDR_BEATS - 1));
  assign data_last = (beat_cnt == CNT_W'(DATA_BEATS - 1));
  assign busy      = (state != HDR) || (hdr_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HDR;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    next_state = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    case (state)
      HDR: begin
        in_ready = 1'b1;
        if (in_valid && hdr_last) next_state = hdr_next[0] ? WDATA : READ;
      end
      WDATA: begin
        in_ready = 1'b1;
        if (in_valid && data_last) next_state = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        next_state = HDR;
      end
      READ:    next_state = RDATA;
      RDATA:   if (out_fire && data_last) next_state = HDR;
      default: next_state = HDR;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_cnt    <= '0;
      beat_cnt   <= '0;
      hdr_reg    <= '0;
      data_reg   <= '0;
      out_valid  <= 1'b0;
      serial_out <= '0;
    end else begin
      case (state)
        HDR: if (in_fire) begin
          hdr_reg <= hdr_next;
          hdr_cnt <= hdr_last ? '0 : hdr_cnt + 1'b1;
        end
        WDATA: if (in_fire) begin
          data_reg <= data_next;
          beat_cnt <= data_last ? '0 : beat_cnt + 1'b1;
        end
        READ: begin
          data_reg   <= mem_rdata[DATA_BITS-1:0];
          out_valid  <= 1'b1;
          serial_out <= mem_rdata[SERIAL_BITS-1:0];
          beat_cnt   <= '0;
        end
        RDATA: if (out_fire) begin
          data_reg <= data_shifted;
          if (data_last) begin
            out_valid  <= 1'b0;
            serial_out <= '0;
            beat_cnt   <= '0;
          end else begin
            serial_out <= data_shifted[SERIAL_BITS-1:0];
            beat_cnt   <= beat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_MEMORY_PARITY_EN
  assign mem_wdata = {^data_reg, data_reg};

  // Flag compares the stored parity with the data as read; it holds until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              parity_err <= 1'b0;
    else if (state == READ) parity_err <= mem_rdata[DATA_BITS] ^ (^mem_rdata[DATA_BITS-1:0]);
  end
`else
  assign mem_wdata  = data_reg;
  assign parity_err = 1'b0;
`endif

  serial_memory_mem_array #(
    .WIDTH    (MEM_W),
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

endmodule
